fetch_queue: RTL and testbench

- Instruction fetch stage directly upstream of the main decoder.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake, with one request outstanding at most.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode with a valid/ready handshake; decode feeds instr[31:26] to the main decoder.
- Accepts a redirect (taken branch or jump) that flushes buffered and in-flight wrong-path instructions.

---
 rtl/fetch_queue.sv | 198 +++++++++++++++++++
 tb/tb_fetch_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage: PC, single-outstanding imem reads, prefetch FIFO, redirect flush
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_queue #(
    parameter int              n        = 32,
    parameter int              DEPTH    = 4,
    parameter logic [n-1:0]    PC_RESET = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [n-1:0] imem_rdata,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [n-1:0] instr,
    output logic [n-1:0] instr_pc,
    input  logic         redirect,
    input  logic [n-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_flushed
`endif
);

    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  FULL     = CW'(DEPTH);
    localparam logic [n-1:0]   PC_STEP  = n'(4);
    localparam logic [n-1:0]   ALIGN    = ~n'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t         state_q, state_d;
    logic [n-1:0]   pc_q, pc_d;
    logic           req_q, req_d;
    logic [n-1:0]   addr_q, addr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic [n-1:0]   mem_instr_q [DEPTH];
    logic [n-1:0]   mem_pc_q    [DEPTH];

    logic           push;
    logic           pop;
    logic [n-1:0]   redir_pc;
    logic [n-1:0]   pc_next;
    logic [CW-1:0]  count_if_push;

    assign redir_pc      = redirect_pc & ALIGN;
    assign pc_next       = pc_q + PC_STEP;
    assign pop           = instr_valid && instr_ready;
    assign count_if_push = count_q + CW'(1) - CW'(pop);

    // pc always names the address of the request in flight (or the next one to issue)
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    pc_d    = redir_pc;
                    req_d   = 1'b1;
                    addr_d  = redir_pc;
                    state_d = S_WAIT;
                end else if (count_q < FULL) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = redir_pc;
                    if (imem_ack) begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end else if (imem_ack) begin
                    push = 1'b1;
                    pc_d = pc_next;
                    if (count_if_push < FULL) begin
                        req_d  = 1'b1;
                        addr_d = pc_next;
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                // the stale request must still complete before a new one can go out
                if (redirect) begin
                    pc_d = redir_pc;
                end
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= PC_RESET;
            req_q    <= 1'b0;
            addr_q   <= PC_RESET;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]    <= pc_q;
        end
    end

    // head is masked to zero when empty so outputs are defined straight out of reset
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? mem_instr_q[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q] : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;
    logic [31:0] flush_amount;

    // buffered entries plus the request still owned by WAIT at the time of the redirect
    assign flush_amount = 32'(count_q) + ((state_q == S_WAIT) ? 32'd1 : 32'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (push) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (redirect) begin
                perf_flushed_q <= perf_flushed_q + flush_amount;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed scoreboard bench for fetch_queue
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
    logic [31:0] flushed_before;
`endif

    int          checks;
    int          failures;
    int          budget_total;
    int          acks_given;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];

    fetch_queue #(
        .n        (32),
        .DEPTH    (4),
        .PC_RESET (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // memory model and decode-side scoreboard, evaluated on the falling edge
    task automatic mem_and_mon();
        logic [31:0] e;
        if (imem_req && (acks_given < budget_total)) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ 32'hA5A5_0000;
            acks_given++;
            check("addr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) begin
                e = exp_addr_q.pop_front();
                check("imem_addr", imem_addr, e);
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
        end
        if (instr_valid && instr_ready && !redirect) begin
            check("pop_expected", 32'(exp_pc_q.size() != 0), 32'd1);
            if (exp_pc_q.size() != 0) begin
                e = exp_pc_q.pop_front();
                check("instr_pc", instr_pc, e);
                check("instr", instr, e ^ 32'hA5A5_0000);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        mem_and_mon();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (exp_pc_q.size() == 0 && exp_addr_q.size() == 0) break;
            step();
        end
        check(tag, 32'(exp_pc_q.size() + exp_addr_q.size()), 32'd0);
    endtask

    task automatic expect_fetch(input logic [31:0] a, input bit deliver);
        exp_addr_q.push_back(a);
        if (deliver) exp_pc_q.push_back(a);
        budget_total++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(imem_req),    32'd0);
        check({tag, "_addr"},  imem_addr,        32'h0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, instr,            32'h0);
        check({tag, "_pc"},    instr_pc,         32'h0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        budget_total = 0;
        acks_given   = 0;
        reset        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        instr_ready  = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;

        // reset state, then first request one cycle after release
        step();
        step();
        check_reset_outputs("rst");
        reset = 1'b1;
        step();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);

        // streaming: zero-wait memory, decode always ready, no bubbles
        for (int i = 0; i < 4; i++) expect_fetch(32'(i * 4), 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stream_valid", 32'(instr_valid), 32'd1);
        end
        drain("drain_stream");

        // FIFO fills with decode stalled, then fetch resumes after pops
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) expect_fetch(32'h10 + 32'(i * 4), 1'b1);
        for (int i = 0; i < 6; i++) step();
        check("full_req", 32'(imem_req), 32'd0);
        check("full_valid", 32'(instr_valid), 32'd1);
        check("full_head_pc", instr_pc, 32'h10);
        instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (imem_req) break;
        end
        check("resume_req", 32'(imem_req), 32'd1);
        check("resume_addr", imem_addr, 32'h20);
        drain("drain_full");

        // redirect while waiting; the stale ack arrives three cycles later
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        exp_addr_q.push_back(32'h20);
        step();
        redirect = 1'b0;
        check("discard_req", 32'(imem_req), 32'd1);
        check("discard_addr", imem_addr, 32'h20);
        check("discard_valid", 32'(instr_valid), 32'd0);
        step();
        step();
        budget_total++;
        expect_fetch(32'h100, 1'b1);
        expect_fetch(32'h104, 1'b1);
        step();
        check("stale_dropped_valid", 32'(instr_valid), 32'd0);
        check("stale_idle_req", 32'(imem_req), 32'd0);
        drain("drain_redirect");

        // redirect coincident with ack and with a pop from a two-entry FIFO
        instr_ready = 1'b0;
        expect_fetch(32'h108, 1'b0);
        expect_fetch(32'h10C, 1'b0);
        step();
        step();
        step();
        check("two_entries_valid", 32'(instr_valid), 32'd1);
        check("two_entries_head", instr_pc, 32'h108);
`ifdef FETCH_PERF_EN
        flushed_before = perf_flushed;
`endif
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        expect_fetch(32'h110, 1'b0);
        step();
        redirect = 1'b0;
        check("flush_valid", 32'(instr_valid), 32'd0);
        check("flush_req", 32'(imem_req), 32'd0);
`ifdef FETCH_PERF_EN
        check("perf_flushed_delta", perf_flushed - flushed_before, 32'd3);
`endif
        step();
        check("post_flush_req", 32'(imem_req), 32'd1);
        check("post_flush_addr", imem_addr, 32'h40);

        // push and pop in one cycle at count=2
        instr_ready = 1'b0;
        expect_fetch(32'h40, 1'b1);
        expect_fetch(32'h44, 1'b1);
        step();
        step();
        step();
        instr_ready = 1'b1;
        expect_fetch(32'h48, 1'b1);
        step();
        instr_ready = 1'b0;
        check("pp_valid", 32'(instr_valid), 32'd1);
        check("pp_head", instr_pc, 32'h44);
        step();
        step();
        check("pp_hold_head", instr_pc, 32'h44);
        instr_ready = 1'b1;
        step();
        step();
        check("pp_empty_after_two", 32'(instr_valid), 32'd0);
        check("pp_sb_empty", 32'(exp_pc_q.size()), 32'd0);

        // PC wrap; low redirect bits are ignored
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        expect_fetch(32'h4C, 1'b0);
        expect_fetch(32'hFFFF_FFFC, 1'b1);
        expect_fetch(32'h0, 1'b1);
        step();
        redirect = 1'b0;
        drain("drain_wrap");
        step();
        check("wrap_next_req", 32'(imem_req), 32'd1);
        check("wrap_next_addr", imem_addr, 32'h4);

        // asynchronous reset mid-WAIT with three entries buffered
        instr_ready = 1'b0;
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        exp_addr_q.push_back(32'hC);
        budget_total += 3;
        for (int i = 0; i < 4; i++) step();
        check("pre_rst_valid", 32'(instr_valid), 32'd1);
        check("pre_rst_head", instr_pc, 32'h4);
        check("pre_rst_req", 32'(imem_req), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        step();
        reset       = 1'b1;
        instr_ready = 1'b1;
        expect_fetch(32'h0, 1'b1);
        step();
        check("restart_req", 32'(imem_req), 32'd1);
        check("restart_addr", imem_addr, 32'h0);
        drain("drain_restart");
        check("acks_used", 32'(acks_given), 32'(budget_total));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
